raster_sequencer: RTL and testbench
===================================

# raster_sequencer

Turns one decoded drawing command (pixel, line, rectangle, clear) into a stream of single-pixel framebuffer writes for the 8x8 display. It sits between the command decoder's `cmd_ready` pulse and the framebuffer write port. It provides a one-deep pending-command buffer and applies back-pressure from the framebuffer through a valid/ready handshake.

## Interface
- No parameters; the grid is fixed at 8x8 with 3-bit coordinates.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: one-cycle command strobe.
- `cmd` input 2: 00 CLEAR, 01 PIXEL, 10 LINE, 11 RECT.
- `x1`, `y1`, `x2`, `y2`, `width`, `height` input 3 each: command operands, sampled only when `cmd_valid`=1.
- `fb_ready` input 1: framebuffer accepts the current write.
- `pix_we` output 1: write valid.
- `pix_x`, `pix_y` output 3 each: write coordinate.
- `pix_val` output 1: 1 = set pixel, 0 = clear pixel.
- `busy` output 1: asserted while state≠IDLE or the pending entry is valid.
- `done` output 1: one-cycle pulse after a command's last write is accepted.
- `cmd_drop` output 1: one-cycle pulse when an incoming command is discarded.

## Operation
- States: IDLE, SETUP, RUN.
  - IDLE→SETUP on an accepted command.
  - SETUP→RUN always, after 1 cycle.
  - RUN→SETUP or IDLE on acceptance of the last write.
- A beat is accepted in any cycle where `pix_we`=1 and `fb_ready`=1. The outputs `pix_x`, `pix_y`, `pix_val` hold stable while `pix_we`=1 and `fb_ready`=0.
- CLEAR: 64 writes with `pix_val`=0 in row-major order: (0,0),(1,0)…(7,0),(0,1)…(7,7). All operands are ignored.
- PIXEL: one write at (`x1`,`y1`) with `pix_val`=1.
- RECT: columns `x1`..min(`x1`+`width`,7) and rows `y1`..min(`y1`+`height`,7), row-major, `pix_val`=1.
  - `width`=0 means one column; `height`=0 means one row.
  - Coordinates clip at 7; there is no wrap-around.
- LINE: Bresenham from (`x1`,`y1`) to (`x2`,`y2`) inclusive, all octants, `pix_val`=1.
  - SETUP computes dx=|x2−x1|, dy=−|y2−y1|, sx/sy=±1, and err=dx+dy (6-bit signed).
  - Per beat:
    - Emit (x,y).
    - If x==x2 and y==y2, the beat is the last.
    - Otherwise, e2=2·err (7-bit signed).
    - If e2≥dy: err+=dy, x+=sx.
    - If e2≤dx: err+=dx, y+=sy.
  - A degenerate line (both endpoints equal) produces one write.
- Command acceptance:
  - In IDLE, a command goes straight to SETUP.
  - When state≠IDLE and the pending entry is empty, the command is stored in pending.
  - When pending is full, the command is dropped and `cmd_drop` pulses the next cycle.
- Last beat accepted while `cmd_valid`=1 in the same cycle:
  - Pending empty: the new command goes to SETUP; nothing is dropped.
  - Pending full: pending goes to SETUP, the new command takes pending; nothing is dropped.
- Last beat accepted with pending valid and no new command: pending goes to SETUP and pending clears.

## Timing
- Reset values: `pix_we`=0, `pix_x`=0, `pix_y`=0, `pix_val`=0, `busy`=0, `done`=0, `cmd_drop`=0; state=IDLE; pending invalid.
- Reset asserted mid-command aborts the command immediately and discards pending. No `done` pulse follows.
- Latency: `cmd_valid` high in cycle N (IDLE) → SETUP in N+1 → first `pix_we` in N+2.
- Throughput: one write per cycle while `fb_ready`=1.
- `done` is high in the cycle after the last accepted beat. A chained command's first `pix_we` follows 2 cycles after that last beat, because SETUP costs one bubble.
- `busy` rises in N+1 and falls in the cycle after the last beat when nothing is pending.
- `cmd_drop` is registered: it is high in the cycle after the dropped strobe.

## Test plan
- Reset, then PIXEL (3,5) with `fb_ready`=1 → a single write (3,5,val 1) in cycle N+2; `done` in N+3; `busy` high during N+1..N+2.
- LINE (0,0)→(7,3) with `fb_ready`=1 → 8 writes: (0,0),(1,0),(2,1),(3,1),(4,2),(5,2),(6,3),(7,3). Repeat reversed (7,3)→(0,0) and check the mirrored sequence.
- RECT x1=6, y1=6, width=3, height=0 → writes (6,6),(7,6) only; no wrap.
- CLEAR with `fb_ready` toggling 1,0,1,0… → exactly 64 writes of val 0 in row-major order; coordinates hold during stalls; 128 cycles from first `pix_we` to `done`.
- Back-to-back commands: PIXEL, then LINE while busy, then RECT while pending full → RECT dropped with a `cmd_drop` pulse; LINE starts 2 cycles after the PIXEL's last beat.
- Assert `rst_n`=0 in the middle of a CLEAR with a command pending → all outputs return to zero asynchronously; after release, no further writes occur.

Source files
------------

// File: rtl/raster_sequencer.sv
// Expands CLEAR / PIXEL / LINE / RECT commands on an 8x8 grid into single-pixel
// framebuffer writes, with a one-deep pending-command buffer and valid/ready back-pressure.
module raster_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid_i,
    input  logic [1:0] cmd_i,
    input  logic [2:0] x1_i,
    input  logic [2:0] y1_i,
    input  logic [2:0] x2_i,
    input  logic [2:0] y2_i,
    input  logic [2:0] width_i,
    input  logic [2:0] height_i,
    input  logic       fb_ready_i,
    output logic       pix_we_o,
    output logic [2:0] pix_x_o,
    output logic [2:0] pix_y_o,
    output logic       pix_val_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       cmd_drop_o
);
    localparam logic [1:0] OpClear = 2'b00;
    localparam logic [1:0] OpPixel = 2'b01;
    localparam logic [1:0] OpLine  = 2'b10;
    localparam logic [1:0] OpRect  = 2'b11;

    typedef enum logic [1:0] {StIdle, StSetup, StRun} state_e;

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] x1;
        logic [2:0] y1;
        logic [2:0] x2;
        logic [2:0] y2;
        logic [2:0] w;
        logic [2:0] h;
    } cmd_t;

    state_e            state_q, state_d;
    cmd_t              cur_q, cur_d, pend_q, pend_d, cmd_in;
    logic              pend_valid_q, pend_valid_d;
    logic [2:0]        x_q, x_d, y_q, y_d;
    logic [2:0]        xs_q, xs_d, xe_q, xe_d, ye_q, ye_d;
    logic signed [5:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic              sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic              done_q, drop_q, drop_d;
    logic              accept, last, fin;

    assign cmd_in = '{op: cmd_i, x1: x1_i, y1: y1_i, x2: x2_i, y2: y2_i,
                      w: width_i, h: height_i};

    assign accept = (state_q == StRun) && fb_ready_i;
    // Every command ends at (xe, ye); PIXEL simply starts there.
    assign last   = (x_q == xe_q) && (y_q == ye_q);
    assign fin    = accept && last;

    // Setup-time geometry derived from the current command.
    logic [2:0]        adx, ady;
    logic [3:0]        rx_sum, ry_sum;
    logic signed [5:0] dx_set, dy_set;
    assign adx    = (cur_q.x2 >= cur_q.x1) ? cur_q.x2 - cur_q.x1 : cur_q.x1 - cur_q.x2;
    assign ady    = (cur_q.y2 >= cur_q.y1) ? cur_q.y2 - cur_q.y1 : cur_q.y1 - cur_q.y2;
    assign rx_sum = {1'b0, cur_q.x1} + {1'b0, cur_q.w};
    assign ry_sum = {1'b0, cur_q.y1} + {1'b0, cur_q.h};
    assign dx_set = {3'b000, adx};
    assign dy_set = 6'sd0 - $signed({3'b000, ady});

    // Bresenham step decision.
    logic signed [6:0] e2, dx_ext, dy_ext;
    logic              step_x, step_y;
    assign e2     = {err_q, 1'b0};
    assign dx_ext = {dx_q[5], dx_q};
    assign dy_ext = {dy_q[5], dy_q};
    assign step_x = e2 >= dy_ext;
    assign step_y = e2 <= dx_ext;

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        drop_d       = 1'b0;
        if (state_q == StIdle) begin
            if (cmd_valid_i) begin
                cur_d   = cmd_in;
                state_d = StSetup;
            end
        end else if (fin) begin
            if (pend_valid_q) begin
                cur_d        = pend_q;
                state_d      = StSetup;
                pend_valid_d = cmd_valid_i;
                if (cmd_valid_i) pend_d = cmd_in;
            end else if (cmd_valid_i) begin
                cur_d   = cmd_in;
                state_d = StSetup;
            end else begin
                state_d = StIdle;
            end
        end else begin
            if (state_q == StSetup) state_d = StRun;
            if (cmd_valid_i) begin
                if (pend_valid_q) begin
                    drop_d = 1'b1;
                end else begin
                    pend_d       = cmd_in;
                    pend_valid_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        xs_d     = xs_q;
        xe_d     = xe_q;
        ye_d     = ye_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        if (state_q == StSetup) begin
            x_d  = cur_q.x1;
            y_d  = cur_q.y1;
            xs_d = cur_q.x1;
            unique case (cur_q.op)
                OpClear: begin
                    x_d  = 3'd0;
                    y_d  = 3'd0;
                    xs_d = 3'd0;
                    xe_d = 3'd7;
                    ye_d = 3'd7;
                end
                OpPixel: begin
                    xe_d = cur_q.x1;
                    ye_d = cur_q.y1;
                end
                OpLine: begin
                    xe_d     = cur_q.x2;
                    ye_d     = cur_q.y2;
                    dx_d     = dx_set;
                    dy_d     = dy_set;
                    err_d    = dx_set + dy_set;
                    sx_neg_d = cur_q.x2 < cur_q.x1;
                    sy_neg_d = cur_q.y2 < cur_q.y1;
                end
                OpRect: begin
                    xe_d = rx_sum[3] ? 3'd7 : rx_sum[2:0];
                    ye_d = ry_sum[3] ? 3'd7 : ry_sum[2:0];
                end
            endcase
        end else if (accept && !last) begin
            if (cur_q.op == OpLine) begin
                err_d = err_q + (step_x ? dy_q : 6'sd0) + (step_y ? dx_q : 6'sd0);
                if (step_x) x_d = sx_neg_q ? x_q - 3'd1 : x_q + 3'd1;
                if (step_y) y_d = sy_neg_q ? y_q - 3'd1 : y_q + 3'd1;
            end else if (x_q == xe_q) begin
                x_d = xs_q;
                y_d = y_q + 3'd1;
            end else begin
                x_d = x_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cur_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            x_q          <= 3'd0;
            y_q          <= 3'd0;
            xs_q         <= 3'd0;
            xe_q         <= 3'd0;
            ye_q         <= 3'd0;
            dx_q         <= 6'sd0;
            dy_q         <= 6'sd0;
            err_q        <= 6'sd0;
            sx_neg_q     <= 1'b0;
            sy_neg_q     <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            x_q          <= x_d;
            y_q          <= y_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ye_q         <= ye_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            err_q        <= err_d;
            sx_neg_q     <= sx_neg_d;
            sy_neg_q     <= sy_neg_d;
            done_q       <= fin;
            drop_q       <= drop_d;
        end
    end

    assign pix_we_o   = (state_q == StRun);
    assign pix_x_o    = x_q;
    assign pix_y_o    = y_q;
    assign pix_val_o  = pix_we_o && (cur_q.op != OpClear);
    assign busy_o     = (state_q != StIdle) || pend_valid_q;
    assign done_o     = done_q;
    assign cmd_drop_o = drop_q;
endmodule

// File: tb/tb_raster_sequencer.sv
// Scoreboard bench for raster_sequencer: stimulus pushes expected writes, a negedge
// monitor pops and compares every write the DUT presents.
module tb_raster_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic [2:0] x1 = 3'd0, y1 = 3'd0, x2 = 3'd0, y2 = 3'd0, width = 3'd0, height = 3'd0;
    logic       fb_ready = 1'b0;
    logic       pix_we, pix_val, busy, done, cmd_drop;
    logic [2:0] pix_x, pix_y;

    raster_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_i      (cmd),
        .x1_i       (x1),
        .y1_i       (y1),
        .x2_i       (x2),
        .y2_i       (y2),
        .width_i    (width),
        .height_i   (height),
        .fb_ready_i (fb_ready),
        .pix_we_o   (pix_we),
        .pix_x_o    (pix_x),
        .pix_y_o    (pix_y),
        .pix_val_o  (pix_val),
        .busy_o     (busy),
        .done_o     (done),
        .cmd_drop_o (cmd_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int v;
        bit last;
    } beat_t;

    beat_t expq[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    exp_drops = 0;
    int    seen_drops = 0;
    bit    prev_last = 1'b0;
    int    lx[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int    ly[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(input int x, input int y, input int v, input bit last);
        beat_t b;
        b.x = x;
        b.y = y;
        b.v = v;
        b.last = last;
        expq.push_back(b);
    endfunction

    // Reference: the pixel list each command must produce.
    function automatic void model(input int op, input int a, input int b, input int c,
                                  input int d, input int w, input int h);
        int xe, ye, x, y, dx, dy, sx, sy, err, e2;
        case (op)
            0: for (int yy = 0; yy < 8; yy++)
                   for (int xx = 0; xx < 8; xx++) push(xx, yy, 0, xx == 7 && yy == 7);
            1: push(a, b, 1, 1'b1);
            2: begin
                x = a; y = b;
                dx = (c > a) ? c - a : a - c;
                dy = -((d > b) ? d - b : b - d);
                sx = (a < c) ? 1 : -1;
                sy = (b < d) ? 1 : -1;
                err = dx + dy;
                for (int k = 0; k < 20; k++) begin
                    push(x, y, 1, x == c && y == d);
                    if (x == c && y == d) break;
                    e2 = 2 * err;
                    if (e2 >= dy) begin err += dy; x += sx; end
                    if (e2 <= dx) begin err += dx; y += sy; end
                end
            end
            default: begin
                xe = (a + w > 7) ? 7 : a + w;
                ye = (b + h > 7) ? 7 : b + h;
                for (int yy = b; yy <= ye; yy++)
                    for (int xx = a; xx <= xe; xx++) push(xx, yy, 1, xx == xe && yy == ye);
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_last <= 1'b0;
        end else begin
            if (done || prev_last) chk("done_pulse", done, prev_last);
            if (cmd_drop) seen_drops <= seen_drops + 1;
            if (pix_we && expq.size() == 0) begin
                chk("unexpected_write", pix_we, 0);
                prev_last <= 1'b0;
            end else if (pix_we) begin
                chk("pix_x", pix_x, expq[0].x);
                chk("pix_y", pix_y, expq[0].y);
                chk("pix_val", pix_val, expq[0].v);
                if (fb_ready) begin
                    prev_last <= expq[0].last;
                    void'(expq.pop_front());
                end else begin
                    prev_last <= 1'b0;
                end
            end else begin
                prev_last <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int op, input int a, input int b, input int c, input int d,
                         input int w, input int h);
        cmd = 2'(op);
        x1 = 3'(a); y1 = 3'(b); x2 = 3'(c); y2 = 3'(d);
        width = 3'(w); height = 3'(h);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (!busy) return;
            @(posedge clk);
            #1;
            if (rnd) fb_ready = ($urandom_range(0, 3) != 0);
        end
        chk("wait_idle_timeout", busy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pix_we"}, pix_we, 0);
        chk({tag, "_pix_x"}, pix_x, 0);
        chk({tag, "_pix_y"}, pix_y, 0);
        chk({tag, "_pix_val"}, pix_val, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cmd_drop"}, cmd_drop, 0);
    endtask

    initial begin
        int first_we, done_c, op, a, b, c, d, w, h;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // PIXEL latency and busy/done timing.
        fb_ready = 1'b1;
        model(1, 3, 5, 0, 0, 0, 0);
        issue(1, 3, 5, 0, 0, 0, 0);
        @(negedge clk);
        chk("pixel_n1_busy", busy, 1);
        chk("pixel_n1_we", pix_we, 0);
        tick();
        @(negedge clk);
        chk("pixel_n2_busy", busy, 1);
        chk("pixel_n2_we", pix_we, 1);
        tick();
        @(negedge clk);
        chk("pixel_n3_done", done, 1);
        chk("pixel_n3_busy", busy, 0);

        // LINE forward and mirrored, against the literal expected sequence.
        for (int i = 0; i < 8; i++) push(lx[i], ly[i], 1, i == 7);
        issue(2, 0, 0, 7, 3, 0, 0);
        wait_idle(1'b0);
        for (int i = 0; i < 8; i++) push(lx[7 - i], ly[7 - i], 1, i == 7);
        issue(2, 7, 3, 0, 0, 0, 0);
        wait_idle(1'b0);

        // RECT clipping at the right edge.
        push(6, 6, 1, 1'b0);
        push(7, 6, 1, 1'b1);
        issue(3, 6, 6, 0, 0, 3, 0);
        wait_idle(1'b0);

        // CLEAR with fb_ready alternating; first pix_we lands on a stall cycle.
        fb_ready = 1'b0;
        model(0, 0, 0, 0, 0, 0, 0);
        issue(0, 5, 2, 1, 7, 3, 4);
        fb_ready = 1'b1;
        first_we = -1;
        done_c = -1000;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pix_we && first_we < 0) first_we = cyc;
            if (done) begin
                done_c = cyc;
                break;
            end
            @(posedge clk);
            #1;
            fb_ready = ~fb_ready;
        end
        chk("clear_we_to_done_cycles", done_c - first_we, 128);
        wait_idle(1'b0);

        // PIXEL, LINE queued, RECT dropped while pending is full.
        fb_ready = 1'b1;
        model(1, 1, 1, 0, 0, 0, 0);
        issue(1, 1, 1, 0, 0, 0, 0);
        model(2, 0, 0, 2, 1, 0, 0);
        issue(2, 0, 0, 2, 1, 0, 0);
        fb_ready = 1'b0;
        exp_drops++;
        issue(3, 2, 2, 0, 0, 1, 1);
        fb_ready = 1'b1;
        @(negedge clk);
        chk("drop_pulse", cmd_drop, 1);
        chk("stalled_pixel_we", pix_we, 1);
        tick();
        @(negedge clk);
        chk("chain_bubble_we", pix_we, 0);
        tick();
        @(negedge clk);
        chk("chain_first_we", pix_we, 1);
        wait_idle(1'b0);

        // Last beat coinciding with a new command while pending is full.
        fb_ready = 1'b1;
        model(1, 0, 7, 0, 0, 0, 0);
        issue(1, 0, 7, 0, 0, 0, 0);
        model(1, 7, 0, 0, 0, 0, 0);
        issue(1, 7, 0, 0, 0, 0, 0);
        model(1, 4, 4, 0, 0, 0, 0);
        issue(1, 4, 4, 0, 0, 0, 0);
        wait_idle(1'b0);

        // Randomized commands with random back-pressure.
        for (int n = 0; n < 30; n++) begin
            op = int'($urandom_range(0, 3));
            a = int'($urandom_range(0, 7)); b = int'($urandom_range(0, 7));
            c = int'($urandom_range(0, 7)); d = int'($urandom_range(0, 7));
            w = int'($urandom_range(0, 7)); h = int'($urandom_range(0, 7));
            model(op, a, b, c, d, w, h);
            issue(op, a, b, c, d, w, h);
            wait_idle(1'b1);
        end

        // Reset mid-CLEAR with a command pending.
        fb_ready = 1'b1;
        model(0, 0, 0, 0, 0, 0, 0);
        issue(0, 0, 0, 0, 0, 0, 0);
        model(1, 2, 2, 0, 0, 0, 0);
        issue(1, 2, 2, 0, 0, 0, 0);
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        expq.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_reset_no_write", pix_we, 0);
            chk("post_reset_idle", busy, 0);
            tick();
        end

        chk("drop_count", seen_drops, exp_drops);
        chk("leftover_expected", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
